// File: rtl/tx_intf_acc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_intf_acc_fetch_pkg
//  Description : Shared FSM encoding and DMG word field positions for the
//                tx_intf accumulator fetch block.
//  Revision    : 1.0  initial release
// ============================================================================
package tx_intf_acc_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CFG      = 3'd1,
        WAIT_TSF = 3'd2,
        STREAM   = 3'd3,
        DONE     = 3'd4
    } state_t;

    // DMG word layout: {cts_toself_config, num_dma_symbol_total}
    localparam int CTS_CFG_MSB = 63;
    localparam int CTS_CFG_LSB = 32;
    localparam int NUM_SYM_MSB = 31;

endpackage
`default_nettype wire

// File: rtl/tx_intf_acc_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tx_intf_acc_skid
//  Description : Two-entry valid/ready skid buffer with occupancy output.
//                The head entry drives o_data directly, so it is stable while
//                o_valid is high and i_ready is low.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_intf_acc_skid #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [0:1];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_occ;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = (r_occ != 2'd0) && i_ready;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign w_push = i_valid && ((r_occ != 2'd2) || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/tx_intf_acc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tx_intf_acc_fetch
//  Description : Pops one DMG/TSF word pair per packet and streams the
//                packet's data words to the AXI-Stream master port.
//                Build option TX_INTF_ACC_FETCH_TSF_GATE_EN holds the stream
//                until the TSF timer reaches the packet's target.
//  Revision    : 1.0  initial release
// ============================================================================
module tx_intf_acc_fetch
    import tx_intf_acc_fetch_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH   = 64,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int TSF_TIMER_WIDTH        = 64
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0] DATA_FROM_FIFO,
    input  logic                            DATA_FIFO_EMPTY,
    output logic                            DATA_FIFO_RDEN,
    input  logic [63:0]                     DMG_FROM_FIFO,
    input  logic                            DMG_FIFO_EMPTY,
    output logic                            DMG_FIFO_RDEN,
    input  logic [TSF_TIMER_WIDTH-1:0]      TSF_FROM_FIFO,
    output logic                            TSF_FIFO_RDEN,
    input  logic [TSF_TIMER_WIDTH-1:0]      tsf_runtime_val,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    input  logic                            M_AXIS_TREADY,
    output logic                            M_AXIS_TLAST,
    output logic [31:0]                     cts_toself_cfg,
    output logic                            busy,
    output logic                            pkt_done,
    output logic                            tsf_late
);

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   r_num_sym;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   r_rd_cnt;
    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   r_tx_cnt;
    logic [31:0]                         r_cts_cfg;
    logic                                r_busy;
    logic                                r_rd_inflight;

    logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   w_num_sym_in;
    logic                                w_dmg_rden;
    logic                                w_data_rden;
    logic                                w_pkt_done;
    logic                                w_tsf_late;
    logic                                w_skid_valid;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]     w_skid_data;
    logic [1:0]                          w_skid_occ;
    logic                                w_beat;
    logic                                w_last;
    logic [2:0]                          w_credit_used;
    logic [2:0]                          w_credit_lim;
    logic                                w_unused_bits;

`ifdef TX_INTF_ACC_FETCH_TSF_GATE_EN
    logic [TSF_TIMER_WIDTH-1:0]          r_tsf_target;
    logic                                r_wait_first;
    assign w_unused_bits = ^DMG_FROM_FIFO[NUM_SYM_MSB:MAX_BIT_NUM_DMA_SYMBOL];
`else
    assign w_unused_bits = ^{DMG_FROM_FIFO[NUM_SYM_MSB:MAX_BIT_NUM_DMA_SYMBOL],
                             TSF_FROM_FIFO, tsf_runtime_val};
`endif

    assign w_num_sym_in = DMG_FROM_FIFO[MAX_BIT_NUM_DMA_SYMBOL-1:0];
    assign w_beat       = w_skid_valid && M_AXIS_TREADY;
    assign w_last       = (r_tx_cnt == r_num_sym - 1'b1);

    // Reads in flight plus buffered words may not exceed the two skid slots;
    // a beat leaving this cycle frees one slot, which keeps 1 word/cycle.
    assign w_credit_used = {1'b0, w_skid_occ} + {2'b00, r_rd_inflight};
    assign w_credit_lim  = 3'd2 + {2'b00, w_beat};
    assign w_data_rden   = (r_state == STREAM) && !DATA_FIFO_EMPTY &&
                           (r_rd_cnt < r_num_sym) && (w_credit_used < w_credit_lim);

    always_comb begin
        w_state_nxt = r_state;
        w_dmg_rden  = 1'b0;
        w_pkt_done  = 1'b0;
        w_tsf_late  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!DMG_FIFO_EMPTY) begin
                    w_dmg_rden  = 1'b1;
                    w_state_nxt = CFG;
                end
            end
            CFG: begin
                if (w_num_sym_in == '0) begin
                    w_pkt_done  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
`ifdef TX_INTF_ACC_FETCH_TSF_GATE_EN
                    w_state_nxt = WAIT_TSF;
`else
                    w_state_nxt = STREAM;
`endif
                end
            end
            WAIT_TSF: begin
`ifdef TX_INTF_ACC_FETCH_TSF_GATE_EN
                if ((r_tsf_target == '0) || (tsf_runtime_val >= r_tsf_target)) begin
                    w_state_nxt = STREAM;
                end
                if (r_wait_first && (r_tsf_target != '0) && (tsf_runtime_val > r_tsf_target)) begin
                    w_tsf_late = 1'b1;
                end
`else
                w_state_nxt = STREAM;
`endif
            end
            STREAM: begin
                if (w_beat && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_pkt_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_num_sym     <= '0;
            r_rd_cnt      <= '0;
            r_tx_cnt      <= '0;
            r_cts_cfg     <= '0;
            r_busy        <= 1'b0;
            r_rd_inflight <= 1'b0;
`ifdef TX_INTF_ACC_FETCH_TSF_GATE_EN
            r_tsf_target  <= '0;
            r_wait_first  <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_rd_inflight <= w_data_rden;
`ifdef TX_INTF_ACC_FETCH_TSF_GATE_EN
            r_wait_first  <= (r_state == CFG);
`endif
            if (r_state == CFG) begin
                r_num_sym <= w_num_sym_in;
                r_cts_cfg <= DMG_FROM_FIFO[CTS_CFG_MSB:CTS_CFG_LSB];
                // Zero-length packets finish in CFG and never raise busy.
                r_busy    <= (w_num_sym_in != '0);
                r_rd_cnt  <= '0;
                r_tx_cnt  <= '0;
`ifdef TX_INTF_ACC_FETCH_TSF_GATE_EN
                r_tsf_target <= TSF_FROM_FIFO;
`endif
            end else begin
                if (w_data_rden) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
                if (w_beat) begin
                    r_tx_cnt <= r_tx_cnt + 1'b1;
                end
            end
            if (r_state == DONE) begin
                r_busy <= 1'b0;
            end
        end
    end

    tx_intf_acc_skid #(
        .DATA_WIDTH (C_M_AXIS_TDATA_WIDTH)
    ) u_skid (
        .clk     (CLK),
        .rst     (RST),
        .i_valid (r_rd_inflight),
        .i_data  (DATA_FROM_FIFO),
        .i_ready (M_AXIS_TREADY),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_occ   (w_skid_occ)
    );

    assign DATA_FIFO_RDEN = w_data_rden;
    assign DMG_FIFO_RDEN  = w_dmg_rden;
    assign TSF_FIFO_RDEN  = w_dmg_rden;
    assign M_AXIS_TDATA   = w_skid_data;
    assign M_AXIS_TVALID  = w_skid_valid;
    assign M_AXIS_TLAST   = w_skid_valid && w_last;
    assign cts_toself_cfg = r_cts_cfg;
    assign busy           = r_busy;
    assign pkt_done       = w_pkt_done;
    assign tsf_late       = w_tsf_late;

endmodule
`default_nettype wire

// File: tb/tb_tx_intf_acc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_intf_acc_fetch
//  Description : Self-checking bench for tx_intf_acc_fetch with queue-based
//                FIFO models and a packet-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tx_intf_acc_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic [63:0] DATA_FROM_FIFO = '0;
    logic        DATA_FIFO_EMPTY;
    logic        DATA_FIFO_RDEN;
    logic [63:0] DMG_FROM_FIFO = '0;
    logic        DMG_FIFO_EMPTY;
    logic        DMG_FIFO_RDEN;
    logic [63:0] TSF_FROM_FIFO = '0;
    logic        TSF_FIFO_RDEN;
    logic [63:0] tsf_runtime_val;
    logic [63:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic        M_AXIS_TLAST;
    logic [31:0] cts_toself_cfg;
    logic        busy;
    logic        pkt_done;
    logic        tsf_late;

    always #5 CLK = ~CLK;

    tx_intf_acc_fetch dut (
        .CLK             (CLK),
        .RST             (RST),
        .DATA_FROM_FIFO  (DATA_FROM_FIFO),
        .DATA_FIFO_EMPTY (DATA_FIFO_EMPTY),
        .DATA_FIFO_RDEN  (DATA_FIFO_RDEN),
        .DMG_FROM_FIFO   (DMG_FROM_FIFO),
        .DMG_FIFO_EMPTY  (DMG_FIFO_EMPTY),
        .DMG_FIFO_RDEN   (DMG_FIFO_RDEN),
        .TSF_FROM_FIFO   (TSF_FROM_FIFO),
        .TSF_FIFO_RDEN   (TSF_FIFO_RDEN),
        .tsf_runtime_val (tsf_runtime_val),
        .M_AXIS_TDATA    (M_AXIS_TDATA),
        .M_AXIS_TVALID   (M_AXIS_TVALID),
        .M_AXIS_TREADY   (M_AXIS_TREADY),
        .M_AXIS_TLAST    (M_AXIS_TLAST),
        .cts_toself_cfg  (cts_toself_cfg),
        .busy            (busy),
        .pkt_done        (pkt_done),
        .tsf_late        (tsf_late)
    );

    // FIFO models: written by the stimulus, popped with 1-cycle read latency
    logic [63:0] data_mem [0:32767];
    logic [63:0] dmg_mem  [0:63];
    logic [63:0] tsf_mem  [0:63];
    int          data_wr = 0, data_rd = 0, dmg_wr = 0, dmg_rd = 0, tsf_rd = 0;
    logic        data_hold = 1'b0;

    assign DATA_FIFO_EMPTY = (data_wr == data_rd) || data_hold;
    assign DMG_FIFO_EMPTY  = (dmg_wr == dmg_rd);

    always @(posedge CLK) begin
        if (DATA_FIFO_RDEN && (data_rd != data_wr)) begin
            DATA_FROM_FIFO <= data_mem[data_rd];
            data_rd        <= data_rd + 1;
        end
        if (DMG_FIFO_RDEN && (dmg_rd != dmg_wr)) begin
            DMG_FROM_FIFO <= dmg_mem[dmg_rd];
            dmg_rd        <= dmg_rd + 1;
        end
        if (TSF_FIFO_RDEN && (tsf_rd != dmg_wr)) begin
            TSF_FROM_FIFO <= tsf_mem[tsf_rd];
            tsf_rd        <= tsf_rd + 1;
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference model state
    int          q_n   [$];
    logic [31:0] q_cfg [$];
    logic [63:0] q_tgt [$];
    logic [64:0] exp_q [$];
    longint      cyc = 0;
    int          cur_n, beats, rds, late_cnt;
    logic [31:0] cur_cfg;
    logic [63:0] cur_tgt, rp2;
    logic        exp_late;
    longint      pop_cyc, exp_first, first_cyc, last_beat_cyc, last_done;

    task automatic tick();
        @(negedge CLK);
        cyc++;
        tsf_runtime_val = tsf_runtime_val + 64'd1;
    endtask

    task automatic load_pkt(input int n, input logic [31:0] cfg, input logic [63:0] tgt,
                            input logic [63:0] base);
        logic [63:0] d;
        dmg_mem[dmg_wr] = {cfg, 32'(n)};
        tsf_mem[dmg_wr] = tgt;
        dmg_wr++;
        q_n.push_back(n);
        q_cfg.push_back(cfg);
        q_tgt.push_back(tgt);
        for (int i = 0; i < n; i++) begin
            d = (base != 0) ? base + 64'(i) : {$urandom, $urandom};
            data_mem[data_wr] = d;
            data_wr++;
            exp_q.push_back({(i == n - 1), d});
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctrl"}, {M_AXIS_TVALID, M_AXIS_TLAST, DATA_FIFO_RDEN, DMG_FIFO_RDEN,
                             TSF_FIFO_RDEN, busy, pkt_done, tsf_late}, 64'd0);
        chk({tag, "_tdata"}, M_AXIS_TDATA, 64'd0);
        chk({tag, "_cfg"}, cts_toself_cfg, 64'd0);
    endtask

    // Expected stream start follows the packet rules from the DMG pop cycle p:
    // CFG at p+1, then either straight to STREAM or through the TSF wait.
    task automatic predict(input longint p);
        longint s;
        rp2      = tsf_runtime_val + 64'd2;
        exp_late = 1'b0;
`ifdef TX_INTF_ACC_FETCH_TSF_GATE_EN
        if (cur_tgt == 0 || rp2 >= cur_tgt) s = p + 3;
        else s = p + 3 + longint'(cur_tgt - rp2);
        exp_late = (cur_n != 0) && (cur_tgt != 0) && (rp2 > cur_tgt);
`else
        s = p + 2;
`endif
        exp_first = s + 2;
    endtask

    // mode 0: TREADY high, 1: TREADY 1010..., 2: random TREADY and data FIFO gaps
    task automatic run(input int npk, input int mode, input int budget, input int stop_beats);
        int          done = 0;
        int          k = 0;
        logic        prev_stall = 1'b0;
        logic [64:0] prev_out = '0;
        logic [64:0] e;
        last_done = -1;
        while (done < npk && k < budget) begin
            case (mode)
                0:       M_AXIS_TREADY = 1'b1;
                1:       M_AXIS_TREADY = (cyc % 2 == 0);
                default: M_AXIS_TREADY = 1'($urandom_range(0, 1));
            endcase
            data_hold = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            #1;
            if (DMG_FIFO_RDEN || TSF_FIFO_RDEN)
                chk("tsf_pop_lockstep", TSF_FIFO_RDEN, DMG_FIFO_RDEN);
            if (DMG_FIFO_RDEN) begin
                chk("dmg_pop_expected", q_n.size() > 0, 1);
                if (last_done >= 0) chk("dmg_pop_gap", cyc, last_done + 1);
                if (q_n.size() > 0) begin
                    cur_n   = q_n.pop_front();
                    cur_cfg = q_cfg.pop_front();
                    cur_tgt = q_tgt.pop_front();
                end
                pop_cyc   = cyc;
                beats     = 0;
                rds       = 0;
                late_cnt  = 0;
                first_cyc = -1;
                predict(cyc);
            end
            if (DATA_FIFO_RDEN) begin
                chk("rden_when_empty", DATA_FIFO_EMPTY, 0);
                rds++;
                chk("rden_within_n", rds <= cur_n, 1);
            end
            if (M_AXIS_TVALID) begin
                chk("cts_cfg", cts_toself_cfg, cur_cfg);
                chk("busy_streaming", busy, 1);
                if (first_cyc < 0) begin
                    first_cyc = cyc;
                    if (mode == 0) chk("first_valid_cyc", cyc, exp_first);
                end
                if (prev_stall) chk("stall_stable", {M_AXIS_TLAST, M_AXIS_TDATA}, prev_out);
                if (M_AXIS_TREADY) begin
                    chk("beat_expected", exp_q.size() > 0, 1);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                    chk("tdata", M_AXIS_TDATA, e[63:0]);
                    chk("tlast", M_AXIS_TLAST, e[64]);
                    if (mode == 0) chk("beat_cycle", cyc, first_cyc + beats);
                    beats++;
                    last_beat_cyc = cyc;
                end
            end
            if (DATA_FIFO_RDEN) chk("outstanding_le2", (rds - beats) <= 2, 1);
            prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_out   = {M_AXIS_TLAST, M_AXIS_TDATA};
            if (tsf_late) begin
                late_cnt++;
                chk("tsf_late_cyc", cyc, pop_cyc + 2);
            end
            if (pkt_done) begin
                chk("done_cyc", cyc, (cur_n == 0) ? pop_cyc + 1 : last_beat_cyc + 1);
                chk("rd_total", rds, cur_n);
                chk("beats_total", beats, cur_n);
                chk("tsf_late_cnt", late_cnt, exp_late);
                done++;
                last_done = cyc;
            end
            if (stop_beats > 0 && beats == stop_beats) break;
            tick();
            k++;
        end
        if (stop_beats == 0) chk("run_complete", done, npk);
        else chk("run_reached_beat", beats, stop_beats);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        RST             = 1'b1;
        M_AXIS_TREADY   = 1'b0;
        tsf_runtime_val = 64'd0;
        tick(); tick();
        #1 chk_idle("reset");
        tick();
        RST           = 1'b0;
        M_AXIS_TREADY = 1'b1;
        #1 chk_idle("post_reset");
        tick();

        // Fixed words 0xA..0xC at full rate
        load_pkt(3, 32'h0, 64'd0, 64'hA);
        run(1, 0, 100, 0);

        // Backpressure 1010...
        load_pkt(4, $urandom, 64'd0, 64'd0);
        run(1, 1, 100, 0);

        // Zero-length packet followed by N=2
        load_pkt(0, 32'hDEAD_0000, 64'd0, 64'd0);
        load_pkt(2, 32'h0000_BEEF, 64'd0, 64'd0);
        run(2, 0, 100, 0);

        // Back-to-back packets, config changes between them
        load_pkt(2, 32'h1111_1111, 64'd0, 64'd0);
        load_pkt(5, 32'h2222_2222, 64'd0, 64'd0);
        run(2, 0, 200, 0);

        // TSF target ahead of the timer, then already passed
        tsf_runtime_val = 64'd988;
        load_pkt(3, 32'h0000_0A0A, 64'd1000, 64'd0);
        run(1, 0, 100, 0);
        tsf_runtime_val = 64'd988;
        load_pkt(2, 32'h0000_0B0B, 64'd500, 64'd0);
        run(1, 0, 100, 0);

        // Randomized packets with random backpressure and FIFO gaps
        for (int i = 0; i < 6; i++) begin
            load_pkt($urandom_range(1, 8), $urandom,
                     ($urandom_range(0, 1) == 0) ? 64'd0 : tsf_runtime_val + 64'($urandom_range(0, 40)),
                     64'd0);
        end
        run(6, 2, 3000, 0);

        // Largest packet length the counter allows
        load_pkt(16383, 32'h5A5A_5A5A, 64'd0, 64'd0);
        run(1, 0, 17000, 0);

        // Reset in the middle of a 5-word packet
        load_pkt(5, 32'h7777_7777, 64'd0, 64'd0);
        run(1, 0, 100, 2);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1 chk_idle("mid_pkt_reset");
        for (int i = 0; i < 8; i++) begin
            tick();
            #1 chk("post_reset_no_rden", {DATA_FIFO_RDEN, DMG_FIFO_RDEN, TSF_FIFO_RDEN}, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
